// File: rtl/gcd_driver.sv
// Purpose: initiator side of the GCD unit handshake. It takes operand pairs, runs the load/x/y bus sequence, waits for done and returns the result.
// Latency: a zero operand gives its result 1 cycle after accept; otherwise load goes out at A+1, x at A+2, y at A+3, and the result follows done by 1 cycle.
// Backpressure: op_ready is high only in IDLE; a result is held stable in RESP until res_ready, with no limit on the wait.
module gcd_driver #(
    parameter int W       = 16,
    parameter int TIMEOUT = 1024,              // must be >= 2
    parameter int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         gcd_load,
    output logic [W-1:0] gcd_din,
    input  logic         gcd_done,
    input  logic [W-1:0] gcd_result,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         res_err,
    output logic         busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SEND_X = 3'd2,
        S_SEND_Y = 3'd3,
        S_WAIT   = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  res_data_q, res_data_d;
    logic [W-1:0]  gcd_din_q, gcd_din_d;
    logic          res_err_q, res_err_d;
    logic          res_valid_q, res_valid_d;
    logic          gcd_load_q, gcd_load_d;
    logic          op_ready_q, op_ready_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] wd_q, wd_d;

    logic accept;
    logic op_zero;
    logic wd_expired;

    // op_ready_q is high exactly when the state is IDLE, so this accept needs no state decode.
    assign accept     = op_valid && op_ready_q;
    assign op_zero    = (op_a == '0) || (op_b == '0);
    assign wd_expired = (wd_q == WD_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Done wins over the watchdog when both happen in the same cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (accept) state_d = op_zero ? S_RESP : S_LOAD;
            S_LOAD:   state_d = S_SEND_X;
            S_SEND_X: state_d = S_SEND_Y;
            S_SEND_Y: state_d = S_WAIT;
            S_WAIT:   if (gcd_done || wd_expired) state_d = S_RESP;
            S_RESP:   if (res_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output and datapath logic. The bus and handshake outputs are computed from the upcoming state so they come straight from flops.
    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        wd_d       = wd_q;

        if (accept) begin
            a_d = op_a;
            b_d = op_b;
            if (op_zero) begin
                // gcd(x,0) = x and gcd(0,0) = 0, so the unit is bypassed.
                res_data_d = op_a | op_b;
                res_err_d  = 1'b0;
            end
        end

        if (state_q == S_WAIT) begin
            wd_d = wd_q + 1'b1;
            if (gcd_done) begin
                res_data_d = gcd_result;
                res_err_d  = 1'b0;
            end else if (wd_expired) begin
                res_data_d = '0;
                res_err_d  = 1'b1;
            end
        end

        if (state_q == S_RESP && res_ready) begin
            wd_d = '0;
        end

        gcd_load_d  = (state_d == S_LOAD);
        res_valid_d = (state_d == S_RESP);
        op_ready_d  = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);

        if (state_d == S_SEND_X) begin
            gcd_din_d = a_d;
        end else if (state_d == S_SEND_Y) begin
            gcd_din_d = b_d;
        end else begin
            gcd_din_d = '0;
        end
    end

    // Datapath and output registers. Reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b0;
            gcd_load_q  <= 1'b0;
            gcd_din_q   <= '0;
            op_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            wd_q        <= '0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
            res_valid_q <= res_valid_d;
            gcd_load_q  <= gcd_load_d;
            gcd_din_q   <= gcd_din_d;
            op_ready_q  <= op_ready_d;
            busy_q      <= busy_d;
            wd_q        <= wd_d;
        end
    end

    assign op_ready  = op_ready_q;
    assign gcd_load  = gcd_load_q;
    assign gcd_din   = gcd_din_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_gcd_driver.sv
// Bench for gcd_driver. It uses a behavioural GCD unit, a table of directed vectors, random pairs and hand-written corner sequences.
// Latency: each transaction is tracked cycle by cycle from the accept edge.
// Backpressure: res_ready is held low for as long as each sequence needs, then released.
module tb_gcd_driver;

    localparam int W = 16;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         op_valid = 1'b0;
    logic         op_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         gcd_load;
    logic [W-1:0] gcd_din;
    logic         gcd_done = 1'b0;
    logic [W-1:0] gcd_result = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] res_data;
    logic         res_err;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    gcd_driver #(.W(W), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .gcd_load   (gcd_load),
        .gcd_din    (gcd_din),
        .gcd_done   (gcd_done),
        .gcd_result (gcd_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_err    (res_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] a, b, t;
        a = x;
        b = y;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Behavioural GCD unit. It takes x and y on the two cycles after the load pulse and raises done m_delay cycles after y.
    // Done then stays high until the next load pulse, so a stale done is always on offer to the driver.
    int           m_delay = 4;
    bit           m_hang = 1'b0;
    bit           m_active = 1'b0;
    int           mk = 0;
    logic [W-1:0] mx = '0;
    logic [W-1:0] my = '0;

    always @(negedge clk) begin
        if (gcd_load) begin
            m_active = 1'b1;
            mk = 0;
            gcd_done = 1'b0;
        end else if (m_active) begin
            mk++;
            if (mk == 1) mx = gcd_din;
            if (mk == 2) my = gcd_din;
            if (mk == 2 + m_delay && !m_hang) begin
                gcd_done = 1'b1;
                gcd_result = ref_gcd(mx, my);
                m_active = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Runs one transaction from IDLE. The call starts and ends at a negedge with op_valid and res_ready low.
    task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b, input int d,
                          input bit hang, input logic [W-1:0] ed, input logic ee, input int elat);
        int k;
        int loads;
        logic [W-1:0] exp_din;
        m_delay = d;
        m_hang  = hang;
        chk({nm, " op_ready"}, 32'(op_ready), 1);
        op_a = a;
        op_b = b;
        op_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        k = 1;
        loads = 0;
        while (!res_valid && k <= 40) begin
            if (gcd_load) loads++;
            exp_din = (elat > 1 && k == 2) ? a : (elat > 1 && k == 3) ? b : '0;
            chk({nm, " gcd_din"}, 32'(gcd_din), 32'(exp_din));
            chk({nm, " busy"}, 32'(busy), 1);
            @(negedge clk);
            k++;
        end
        if (gcd_load) loads++;
        chk({nm, " latency"}, 32'(k), 32'(elat));
        chk({nm, " res_data"}, 32'(res_data), 32'(ed));
        chk({nm, " res_err"}, 32'(res_err), 32'(ee));
        chk({nm, " load_pulses"}, 32'(loads), (elat > 1) ? 1 : 0);
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        chk({nm, " res_valid_drop"}, 32'(res_valid), 0);
    endtask

    // Starts a nonzero transaction and pulses reset on the kk-th cycle after accept.
    task automatic reset_at(input string nm, input int kk);
        m_delay = 4;
        m_hang  = 1'b0;
        op_a = 16'd48;
        op_b = 16'd18;
        op_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        for (int k = 1; k < kk; k++) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk({nm, " gcd_load"}, 32'(gcd_load), 0);
        chk({nm, " gcd_din"}, 32'(gcd_din), 0);
        chk({nm, " res_valid"}, 32'(res_valid), 0);
        chk({nm, " res_data"}, 32'(res_data), 0);
        chk({nm, " res_err"}, 32'(res_err), 0);
        chk({nm, " busy"}, 32'(busy), 0);
        chk({nm, " op_ready"}, 32'(op_ready), 1);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk({nm, " no_result"}, 32'(res_valid), 0);
        end
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           d;
        bit           hang;
        logic [W-1:0] ed;
        logic         ee;
        int           elat;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic [W-1:0] ra, rb;
        int rd;

        // Directed vectors. Latency counts cycles from accept to res_valid: 1 for a zero operand, 4+d for a unit computing in d cycles, 12 on timeout.
        tbl[0]  = '{16'd48,    16'd18,    4, 1'b0, 16'd6,     1'b0, 8};
        tbl[1]  = '{16'd0,     16'd35,    1, 1'b0, 16'd35,    1'b0, 1};
        tbl[2]  = '{16'd0,     16'd0,     1, 1'b0, 16'd0,     1'b0, 1};
        tbl[3]  = '{16'd35,    16'd0,     1, 1'b0, 16'd35,    1'b0, 1};
        tbl[4]  = '{16'd27,    16'd18,    2, 1'b0, 16'd9,     1'b0, 6};
        tbl[5]  = '{16'd21,    16'd14,    2, 1'b0, 16'd7,     1'b0, 6};
        tbl[6]  = '{16'd5,     16'd10,    1, 1'b1, 16'd0,     1'b1, 12};
        tbl[7]  = '{16'd12,    16'd8,     8, 1'b0, 16'd4,     1'b0, 12};
        tbl[8]  = '{16'd7,     16'd7,     1, 1'b0, 16'd7,     1'b0, 5};
        tbl[9]  = '{16'd65535, 16'd65535, 3, 1'b0, 16'd65535, 1'b0, 7};
        tbl[10] = '{16'd1,     16'd65535, 1, 1'b0, 16'd1,     1'b0, 5};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset op_ready", 32'(op_ready), 1);
        chk("reset res_valid", 32'(res_valid), 0);
        chk("reset gcd_load", 32'(gcd_load), 0);
        chk("reset gcd_din", 32'(gcd_din), 0);
        chk("reset res_data", 32'(res_data), 0);
        chk("reset res_err", 32'(res_err), 0);
        chk("reset busy", 32'(busy), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].hang,
                   tbl[i].ed, tbl[i].ee, tbl[i].elat);
        end

        // Backpressure: hold the result for 20 cycles with a competing pair on offer.
        m_delay = 4;
        m_hang  = 1'b0;
        op_a = 16'd48;
        op_b = 16'd18;
        op_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_a = 16'd0;
        op_b = 16'd5;
        for (int k = 0; k < 40 && !res_valid; k++) @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            chk("bp res_valid", 32'(res_valid), 1);
            chk("bp res_data", 32'(res_data), 6);
            chk("bp op_ready", 32'(op_ready), 0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        chk("bp release res_valid", 32'(res_valid), 0);
        chk("bp release op_ready", 32'(op_ready), 1);
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        chk("bp next res_valid", 32'(res_valid), 1);
        chk("bp next res_data", 32'(res_data), 5);
        chk("bp next op_ready", 32'(op_ready), 0);
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;

        // Reset during SEND_Y (3rd cycle after accept) and during WAIT (5th cycle).
        reset_at("rst_sendy", 3);
        reset_at("rst_wait", 5);
        run_op("after_rst", 16'd100, 16'd75, 4, 1'b0, 16'd25, 1'b0, 8);

        // Random pairs checked against plain Euclid.
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 3000));
            rb = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 3000));
            rd = $urandom_range(1, 7);
            run_op($sformatf("rnd%0d", i), ra, rb, rd, 1'b0, ref_gcd(ra, rb), 1'b0,
                   (ra == 0 || rb == 0) ? 1 : 4 + rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/gcd_driver.md
Name: gcd_driver

Overview:
- Initiator side of the GCD controller handshake.
- Accepts operand pairs on an upstream valid/ready interface, sequences the load pulse and the two operand words onto the GCD unit's shared data bus, waits for done, and returns the result on a downstream valid/ready interface.
- Handles zero operands without the GCD unit, and flags a hung unit with a watchdog.

Parameters:
- W, 16, operand/result width in bits.
- TIMEOUT, 1024, max cycles in WAIT before error; must be ≥ 2.
- CW, $clog2(TIMEOUT+1), watchdog counter width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- op_valid  in  1  upstream operand pair valid.
- op_ready  out  1  driver can accept a pair.
- op_a  in  W  first operand.
- op_b  in  W  second operand.
- gcd_load  out  1  one-cycle start pulse to the GCD unit.
- gcd_din  out  W  operand bus to the GCD unit.
- gcd_done  in  1  GCD unit done level.
- gcd_result  in  W  GCD unit result; valid while gcd_done=1.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts result.
- res_data  out  W  GCD result.
- res_err  out  1  1 = watchdog expired, res_data=0.
- busy  out  1  1 whenever state ≠ IDLE.

Behaviour:
- States: IDLE, LOAD, SEND_X, SEND_Y, WAIT, RESP.
- Reset: state=IDLE; gcd_load=0; gcd_din=0; res_valid=0; res_data=0; res_err=0; watchdog=0; captured operands=0.
- Reset mid-operation abandons the transaction. No result is emitted.
- op_ready = 1 only in IDLE. An accept happens when op_valid && op_ready; op_a and op_b are captured into a_q and b_q on that edge.
- IDLE, on accept:
  - If op_a==0 or op_b==0: go to RESP with res_data = op_a|op_b (gcd(x,0)=x; gcd(0,0)=0), res_err=0. The GCD unit is not touched.
  - Otherwise: go to LOAD.
- LOAD: gcd_load=1 for exactly this cycle, gcd_din=0. Next state SEND_X.
- SEND_X: gcd_din=a_q. Next state SEND_Y.
- SEND_Y: gcd_din=b_q. Next state WAIT. Operand bus timing relative to the load pulse cycle T: x at T+1, y at T+2.
- WAIT: gcd_din=0.
  - Watchdog increments every WAIT cycle, starting from 0.
  - gcd_done is sampled only in WAIT. A done level left over from a previous operation drops by T+1, so it is ignored.
  - If gcd_done=1: capture gcd_result into res_data, res_err=0, go to RESP.
  - Else if watchdog==TIMEOUT-1: res_data=0, res_err=1, go to RESP.
  - gcd_done has priority over the watchdog in the same cycle.
- RESP:
  - res_valid=1. res_data and res_err are held stable until res_ready.
  - On res_valid && res_ready: res_valid=0, watchdog=0, go to IDLE. The next pair can be accepted the cycle after the handshake; there is no combinational ready path from res_ready to op_ready.
  - Backpressure: RESP holds indefinitely while res_ready=0.
- gcd_load is never asserted outside LOAD. gcd_din=0 in all states except SEND_X and SEND_Y.
- Latency:
  - Nonzero operands, accept cycle A: LOAD=A+1, SEND_X=A+2, SEND_Y=A+3. WAIT begins at A+4. res_valid rises the cycle after done is sampled in WAIT.
  - Zero operand: res_valid at A+1.
- Registered outputs only; no combinational path from any input to any output.

Test Plan:
- Basic, with a behavioural GCD model (4-cycle compute): op_a=48, op_b=18 → one gcd_load pulse; gcd_din=48 then 18 on the next two cycles; res_valid with res_data=6, res_err=0; busy high throughout.
- Zero bypass: (0,35) → res_data=35 at A+1; (0,0) → res_data=0; gcd_load never pulses.
- Watchdog, TIMEOUT=8, gcd_done held 0: res_err=1, res_data=0 after exactly 8 WAIT cycles. A done arriving in the same cycle as expiry yields res_err=0 with the captured result.
- Backpressure: res_ready=0 for 20 cycles → res_valid stays 1, res_data is stable, op_ready=0, an offered op_valid is not accepted. Releasing res_ready → IDLE, and the next pair is accepted one cycle later.
- Stale done: the model keeps gcd_done=1 (previous result 9) until it sees the load pulse; new pair (21,14) → res_data=7, not 9.
- Reset mid-operation: assert rst during SEND_Y and again during WAIT → all outputs return to reset values next cycle; no res_valid; a following pair (100,75) completes with res_data=25.
